ippcsge_pcssync: RTL and testbench

The Gigabit Ethernet PCS receive synchronization stage performs code-group alignment qualification, following the 1000BASE-X synchronization process. It consumes one decoded 8B/10B code group per clock from the 10b/8b decoder. It produces `sync`, `rx_even`, `code_err` and `di` for the downstream PCS receive state machine in `ippcsge`. It also counts loss-of-sync events for management.

---
 rtl/ippcsge_pcssync.sv | 141 ++++++++++++++
 tb/tb_ippcsge_pcssync.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ippcsge_pcssync.sv
// rtl/ippcsge_pcssync.sv - 1000BASE-X PCS receive code-group synchronization stage
module ippcsge_pcssync #(
    parameter int GOOD_CGS_MAX = 3
) (
    input  logic       clk,
    input  logic       rst_,
    input  logic       sigdet,
    input  logic [8:0] di_in,
    input  logic       cerr_in,
    input  logic       comma_in,
    input  logic       cnt_clr,
    output logic       sync,
    output logic       rx_even,
    output logic       code_err,
    output logic [8:0] di,
    output logic [3:0] sync_state,
    output logic [7:0] los_cnt
);

    typedef enum logic [3:0] {
        ST_LOS  = 4'd0,
        ST_CD1  = 4'd1,
        ST_AS1  = 4'd2,
        ST_CD2  = 4'd3,
        ST_AS2  = 4'd4,
        ST_CD3  = 4'd5,
        ST_SA1  = 4'd6,
        ST_SA2  = 4'd7,
        ST_SA2A = 4'd8,
        ST_SA3  = 4'd9,
        ST_SA3A = 4'd10,
        ST_SA4  = 4'd11,
        ST_SA4A = 4'd12
    } state_t;

    localparam logic [1:0] GOOD_LAST = 2'(GOOD_CGS_MAX - 1);

    state_t      state_q, state_d;
    logic        par_q, par_d;
    logic [1:0]  good_q, good_d;
    logic [7:0]  los_q, los_d;
    logic        sync_q, sync_d;
    logic        code_err_q;
    logic [8:0]  di_q;
    logic        dgrp, cgbad, in_sa;

    always_comb begin
        par_d = ~par_q;
        if (state_q == ST_LOS && sigdet && comma_in) begin
            par_d = 1'b1;
        end
        dgrp  = !cerr_in && !di_in[8];
        cgbad = cerr_in || (comma_in && !par_d);

        state_d = state_q;
        good_d  = good_q;
        case (state_q)
            ST_LOS:  if (comma_in) state_d = ST_CD1;
            ST_CD1:  state_d = dgrp ? ST_AS1 : ST_LOS;
            ST_CD2:  state_d = dgrp ? ST_AS2 : ST_LOS;
            ST_CD3:  state_d = dgrp ? ST_SA1 : ST_LOS;
            ST_AS1: begin
                if (cgbad)                 state_d = ST_LOS;
                else if (comma_in && par_d) state_d = ST_CD2;
            end
            ST_AS2: begin
                if (cgbad)                 state_d = ST_LOS;
                else if (comma_in && par_d) state_d = ST_CD3;
            end
            ST_SA1: begin
                if (cgbad) begin
                    state_d = ST_SA2;
                    good_d  = 2'd0;
                end
            end
            // The good group that leaves SA_n for SA_nA is the first one counted.
            ST_SA2, ST_SA3, ST_SA4: begin
                if (cgbad) begin
                    state_d = (state_q == ST_SA4) ? ST_LOS : state_t'(state_q + 4'd2);
                    good_d  = 2'd0;
                end else begin
                    state_d = state_t'(state_q + 4'd1);
                    good_d  = 2'd1;
                end
            end
            ST_SA2A, ST_SA3A, ST_SA4A: begin
                if (cgbad) begin
                    state_d = (state_q == ST_SA4A) ? ST_LOS : state_t'(state_q + 4'd1);
                    good_d  = 2'd0;
                end else if (good_q == GOOD_LAST) begin
                    state_d = (state_q == ST_SA2A) ? ST_SA1 : state_t'(state_q - 4'd3);
                    good_d  = 2'd0;
                end else begin
                    good_d  = good_q + 2'd1;
                end
            end
            default: state_d = ST_LOS;
        endcase
        if (!sigdet) begin
            state_d = ST_LOS;
        end

        in_sa  = (state_q >= ST_SA1) && (state_q <= ST_SA4A);
        sync_d = (state_d >= ST_SA1) && (state_d <= ST_SA4A);

        los_d = los_q;
        if (cnt_clr) begin
            los_d = 8'd0;
        end else if (in_sa && state_d == ST_LOS && los_q != 8'hFF) begin
            los_d = los_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q    <= ST_LOS;
            par_q      <= 1'b0;
            good_q     <= 2'd0;
            los_q      <= 8'd0;
            sync_q     <= 1'b0;
            code_err_q <= 1'b0;
            di_q       <= 9'd0;
        end else begin
            state_q    <= state_d;
            par_q      <= par_d;
            good_q     <= good_d;
            los_q      <= los_d;
            sync_q     <= sync_d;
            code_err_q <= cerr_in;
            di_q       <= di_in;
        end
    end

    assign sync       = sync_q;
    assign rx_even    = par_q;
    assign code_err   = code_err_q;
    assign di         = di_q;
    assign sync_state = state_q;
    assign los_cnt    = los_q;

endmodule

// File: tb/tb_ippcsge_pcssync.sv
// tb/tb_ippcsge_pcssync.sv - scoreboard bench for ippcsge_pcssync against a level/stage model
module tb_ippcsge_pcssync;

    localparam int GOOD_MAX = 3;
    localparam logic [8:0] K285 = 9'h1BC;
    localparam logic [8:0] D162 = 9'h050;

    logic       clk = 1'b0;
    logic       rst_;
    logic       sigdet;
    logic [8:0] di_in;
    logic       cerr_in;
    logic       comma_in;
    logic       cnt_clr;
    logic       sync;
    logic       rx_even;
    logic       code_err;
    logic [8:0] di;
    logic [3:0] sync_state;
    logic [7:0] los_cnt;

    ippcsge_pcssync #(.GOOD_CGS_MAX(GOOD_MAX)) dut (
        .clk(clk), .rst_(rst_), .sigdet(sigdet), .di_in(di_in), .cerr_in(cerr_in),
        .comma_in(comma_in), .cnt_clr(cnt_clr), .sync(sync), .rx_even(rx_even),
        .code_err(code_err), .di(di), .sync_state(sync_state), .los_cnt(los_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       sync;
        logic       even;
        logic       cerr;
        logic [8:0] di;
        logic [3:0] st;
        logic [7:0] los;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   phase  = 0;

    // Model: acquisition stage (0..5), or in sync at a tolerance level 1..4
    int acq, level, good, mlos;
    bit m_sync, mpar;

    task automatic model_reset();
        acq = 0; level = 1; good = 0; mlos = 0; m_sync = 0; mpar = 0;
    endtask

    function automatic logic [3:0] model_state();
        if (!m_sync)    return 4'(acq);
        if (level == 1) return 4'd6;
        return 4'(2 * level + 3 + ((good > 0) ? 1 : 0));
    endfunction

    task automatic send(input bit sd, input logic [8:0] d, input bit ce, input bit cm, input bit clr);
        bit bad;
        bit lost;
        @(negedge clk);
        sigdet = sd; di_in = d; cerr_in = ce; comma_in = cm; cnt_clr = clr;
        lost = 0;
        if (!sd) begin
            mpar = ~mpar;
            if (m_sync) lost = 1;
            m_sync = 0; acq = 0;
        end else if (!m_sync) begin
            if (acq == 0) begin
                if (cm) begin mpar = 1; acq = 1; end
                else mpar = ~mpar;
            end else begin
                mpar = ~mpar;
                if (acq % 2 == 1) begin
                    if (!ce && !d[8]) begin
                        if (acq == 5) begin m_sync = 1; level = 1; good = 0; end
                        else acq++;
                    end else acq = 0;
                end else begin
                    bad = ce || (cm && !mpar);
                    if (bad) acq = 0;
                    else if (cm) acq++;
                end
            end
        end else begin
            mpar = ~mpar;
            bad = ce || (cm && !mpar);
            if (bad) begin
                if (level == 4) begin m_sync = 0; acq = 0; lost = 1; end
                else begin level++; good = 0; end
            end else if (level > 1) begin
                good++;
                if (good == GOOD_MAX) begin level--; good = 0; end
            end
        end
        if (clr) mlos = 0;
        else if (lost && mlos < 255) mlos++;
        q.push_back({m_sync, mpar, ce, d, model_state(), 8'(mlos)});
    endtask

    task automatic kd(input int n);
        for (int i = 0; i < n; i++) begin
            send(1, K285, 0, 1, 0);
            send(1, D162, 0, 0, 0);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        exp_t got;
        #1;
        if (q.size() > 0) begin
            e   = q.pop_front();
            got = {sync, rx_even, code_err, di, sync_state, los_cnt};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL scoreboard phase=%0d got sync=%b even=%b cerr=%b di=%h st=%0d los=%0d required sync=%b even=%b cerr=%b di=%h st=%0d los=%0d",
                         phase, got.sync, got.even, got.cerr, got.di, got.st, got.los,
                         e.sync, e.even, e.cerr, e.di, e.st, e.los);
            end
        end
    end

    task automatic check_reset(input int tag);
        checks++;
        if ({sync, rx_even, code_err, di, sync_state, los_cnt} !== 26'd0) begin
            errors++;
            $display("FAIL reset_state tag=%0d got sync=%b even=%b cerr=%b di=%h st=%0d los=%0d required all zero",
                     tag, sync, rx_even, code_err, di, sync_state, los_cnt);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got pending=%0d required 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        int r;
        bit want_k;
        rst_ = 0; sigdet = 0; di_in = 0; cerr_in = 0; comma_in = 0; cnt_clr = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset(0);
        rst_ = 1;

        phase = 1; kd(5);
        phase = 2; send(1, 9'h1AA, 1, 0, 0); send(1, D162, 0, 0, 0); kd(1); kd(2);
        phase = 3; repeat (4) send(1, 9'h0F3, 1, 0, 0);
        phase = 4; kd(1); send(1, D162, 0, 0, 0); send(1, K285, 0, 1, 0); send(1, D162, 0, 0, 0);
        phase = 5; kd(4); send(0, D162, 0, 0, 0); kd(4);
        phase = 6; kd(1); send(1, D162, 0, 0, 0); send(1, K285, 0, 1, 0); kd(2);

        drain();
        @(negedge clk);
        rst_ = 0;
        model_reset();
        #1;
        check_reset(1);
        @(negedge clk);
        rst_ = 1;

        phase = 7;
        want_k = 1;
        for (int i = 0; i < 2000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r == 0) begin
                send(0, 9'($urandom), 0, 0, 0);
            end else if (r < 4) begin
                send(1, 9'($urandom), 1, $urandom_range(0, 1) == 1, 0);
            end else if (r < 6) begin
                send(1, 9'({1'b0, 8'($urandom)}), 0, 0, 0);
            end else if (r < 7) begin
                send(1, D162, 0, 0, 1);
            end else if (want_k) begin
                send(1, K285, 0, 1, 0);
            end else begin
                send(1, 9'({1'b0, 8'($urandom)}), 0, 0, 0);
            end
            want_k = ~want_k;
        end

        phase = 8;
        for (int i = 0; i < 260; i++) begin
            kd(3);
            send(0, D162, 0, 0, 0);
        end
        phase = 9; kd(3); send(0, D162, 0, 0, 1); kd(3);

        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
